// File: rtl/execute_mc_if.sv
// Handshake and payload bundle between the issue stage and execute_mc.
// The issuer holds the master view; the execute stage holds the slave view.
interface execute_mc_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            is_store;
    logic            is_load;
    logic            is_branch;
    logic            is_jump;
    logic            is_reg;
    logic            is_alu;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] branch_dest;
    logic [XLEN-1:0] curr_pc;
    logic [4:0]      dest_i;
    logic [2:0]      func3;
    logic            func7;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] next_pc;
    logic [4:0]      dest_o;
    logic            busy;

    modport master (
        output in_valid, is_store, is_load, is_branch, is_jump, is_reg, is_alu,
        output operand_a, operand_b, branch_dest, curr_pc, dest_i, func3, func7,
        output out_ready,
        input  in_ready, out_valid, result, next_pc, dest_o, busy
    );

    modport slave (
        input  in_valid, is_store, is_load, is_branch, is_jump, is_reg, is_alu,
        input  operand_a, operand_b, branch_dest, curr_pc, dest_i, func3, func7,
        input  out_ready,
        output in_ready, out_valid, result, next_pc, dest_o, busy
    );
endinterface

// File: rtl/execute_mc.sv
// Multi-cycle execute stage: single-cycle ALU/branch/jump/address ops plus an
// iterative shifter that retires SHIFT_STEP bit positions per cycle.
module execute_mc #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input logic         clk,
    input logic         reset,
    execute_mc_if.slave bus
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = SHW + 1;
    localparam logic [CW-1:0]   STEP_C = CW'(SHIFT_STEP);
    localparam logic [XLEN-1:0] FOUR   = XLEN'(4);

    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} sh_kind_t;

    state_t          state, state_next;
    logic            out_valid, out_valid_next;
    logic [XLEN-1:0] result, result_next;
    logic [XLEN-1:0] next_pc, next_pc_next;
    logic [4:0]      dest, dest_next;
    logic [XLEN-1:0] sh_val, sh_val_next;
    logic [CW-1:0]   sh_rem, sh_rem_next;
    sh_kind_t        sh_kind, sh_kind_next;

    logic            accept;
    logic            taken;
    logic [XLEN-1:0] a, b, pc_plus4;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] d_result, d_next_pc;
    logic [4:0]      d_dest;
    logic            d_shift;
    sh_kind_t        d_kind;
    logic [CW-1:0]   step_amt;
    logic [XLEN-1:0] sh_out;

    assign a        = bus.operand_a;
    assign b        = bus.operand_b;
    assign shamt    = bus.operand_b[SHW-1:0];
    assign pc_plus4 = bus.curr_pc + FOUR;

    assign bus.in_ready  = (state == IDLE) && (!out_valid || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.busy      = (state == SHIFT);
    assign bus.out_valid = out_valid;
    assign bus.result    = result;
    assign bus.next_pc   = next_pc;
    assign bus.dest_o    = dest;

    // Branch condition; unused encodings fall through as not taken
    always_comb begin
        taken = 1'b0;
        case (bus.func3)
            3'b000:  taken = (a == b);
            3'b001:  taken = (a != b);
            3'b100:  taken = ($signed(a) <  $signed(b));
            3'b101:  taken = ($signed(a) >= $signed(b));
            3'b110:  taken = (a <  b);
            3'b111:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

    // Operation decode, priority branch > jump > load/store > alu > nop
    always_comb begin
        d_result  = '0;
        d_next_pc = pc_plus4;
        d_dest    = '0;
        d_shift   = 1'b0;
        d_kind    = SH_LL;
        if (bus.is_branch) begin
            if (taken) d_next_pc = bus.curr_pc + bus.branch_dest;
        end else if (bus.is_jump) begin
            d_result  = pc_plus4;
            d_dest    = bus.dest_i;
            d_next_pc = bus.is_reg ? ((a + b) & ~XLEN'(1)) : (bus.curr_pc + a);
        end else if (bus.is_load || bus.is_store) begin
            d_result = a + b;
            d_dest   = bus.is_load ? bus.dest_i : 5'd0;
        end else if (bus.is_alu) begin
            d_dest = bus.dest_i;
            case (bus.func3)
                3'b000: d_result = bus.func7 ? (a - b) : (a + b);
                3'b010: d_result = XLEN'($signed(a) < $signed(b));
                3'b011: d_result = XLEN'(a < b);
                3'b100: d_result = a ^ b;
                3'b110: d_result = a | b;
                3'b111: d_result = a & b;
                3'b001: begin
                    d_result = a;
                    d_shift  = (shamt != '0);
                    d_kind   = SH_LL;
                end
                3'b101: begin
                    d_result = a;
                    d_shift  = (shamt != '0);
                    d_kind   = bus.func7 ? SH_RA : SH_RL;
                end
            endcase
        end
    end

    // One shifter iteration; the final step may be shorter than SHIFT_STEP
    always_comb begin
        step_amt = (sh_rem > STEP_C) ? STEP_C : sh_rem;
        case (sh_kind)
            SH_RL:   sh_out = sh_val >> step_amt;
            SH_RA:   sh_out = XLEN'($signed(sh_val) >>> step_amt);
            default: sh_out = sh_val << step_amt;
        endcase
    end

    // next_pc/dest are loaded on shift entry since out_valid stays low until done
    always_comb begin
        state_next     = state;
        out_valid_next = out_valid && !bus.out_ready;
        result_next    = result;
        next_pc_next   = next_pc;
        dest_next      = dest;
        sh_val_next    = sh_val;
        sh_rem_next    = sh_rem;
        sh_kind_next   = sh_kind;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_pc_next = d_next_pc;
                    dest_next    = d_dest;
                    if (d_shift) begin
                        state_next     = SHIFT;
                        out_valid_next = 1'b0;
                        sh_val_next    = a;
                        sh_rem_next    = CW'(shamt);
                        sh_kind_next   = d_kind;
                    end else begin
                        out_valid_next = 1'b1;
                        result_next    = d_result;
                    end
                end
            end
            SHIFT: begin
                sh_val_next = sh_out;
                sh_rem_next = sh_rem - step_amt;
                if (sh_rem <= STEP_C) begin
                    state_next     = IDLE;
                    out_valid_next = 1'b1;
                    result_next    = sh_out;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            next_pc   <= '0;
            dest      <= '0;
            sh_val    <= '0;
            sh_rem    <= '0;
            sh_kind   <= SH_LL;
        end else begin
            out_valid <= out_valid_next;
            result    <= result_next;
            next_pc   <= next_pc_next;
            dest      <= dest_next;
            sh_val    <= sh_val_next;
            sh_rem    <= sh_rem_next;
            sh_kind   <= sh_kind_next;
        end
    end
endmodule

// File: tb/tb_execute_mc.sv
// Bench for execute_mc: directed vector table, random ops against a reference
// model, and hand-written backpressure / mid-shift reset sequences.
module tb_execute_mc;
    localparam int unsigned XLEN = 32;
    localparam logic [5:0] F_BR = 6'b100000, F_JP = 6'b010000, F_LD = 6'b001000;
    localparam logic [5:0] F_ST = 6'b000100, F_AL = 6'b000010, F_RG = 6'b000001;

    typedef struct {
        logic [5:0]  fl;
        logic [31:0] a, b, bd, pc;
        logic [4:0]  d;
        logic [2:0]  f3;
        logic        f7;
    } op_t;
    typedef struct {
        logic [31:0] r, np;
        logic [4:0]  d;
        int          lat;
    } exp_t;
    typedef struct {
        op_t  op;
        bit   sel;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    execute_mc_if #(.XLEN(XLEN)) if1 ();
    execute_mc_if #(.XLEN(XLEN)) if4 ();
    execute_mc #(.XLEN(XLEN), .SHIFT_STEP(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    execute_mc #(.XLEN(XLEN), .SHIFT_STEP(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));

    logic sel = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    op_t  cur = '{default: '0};

    assign if1.in_valid = in_valid && !sel;
    assign if4.in_valid = in_valid && sel;
    assign {if1.is_branch, if1.is_jump, if1.is_load, if1.is_store, if1.is_alu, if1.is_reg} = cur.fl;
    assign {if4.is_branch, if4.is_jump, if4.is_load, if4.is_store, if4.is_alu, if4.is_reg} = cur.fl;
    assign if1.operand_a = cur.a;   assign if4.operand_a = cur.a;
    assign if1.operand_b = cur.b;   assign if4.operand_b = cur.b;
    assign if1.branch_dest = cur.bd; assign if4.branch_dest = cur.bd;
    assign if1.curr_pc = cur.pc;    assign if4.curr_pc = cur.pc;
    assign if1.dest_i = cur.d;      assign if4.dest_i = cur.d;
    assign if1.func3 = cur.f3;      assign if4.func3 = cur.f3;
    assign if1.func7 = cur.f7;      assign if4.func7 = cur.f7;
    assign if1.out_ready = out_ready;
    assign if4.out_ready = out_ready;

    logic        o_valid, i_ready, o_busy;
    logic [31:0] o_result, o_npc;
    logic [4:0]  o_dest;
    assign o_valid  = sel ? if4.out_valid : if1.out_valid;
    assign i_ready  = sel ? if4.in_ready  : if1.in_ready;
    assign o_busy   = sel ? if4.busy      : if1.busy;
    assign o_result = sel ? if4.result    : if1.result;
    assign o_npc    = sel ? if4.next_pc   : if1.next_pc;
    assign o_dest   = sel ? if4.dest_o    : if1.dest_o;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic op_t mkop(input logic [5:0] fl, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] bd, input logic [31:0] pc, input logic [4:0] d,
                                 input logic [2:0] f3, input logic f7);
        op_t o;
        o.fl = fl; o.a = a; o.b = b; o.bd = bd; o.pc = pc; o.d = d; o.f3 = f3; o.f7 = f7;
        return o;
    endfunction

    // Reference behaviour computed directly from the operation rules
    function automatic exp_t model(input op_t o, input int step);
        exp_t e;
        int   sh;
        bit   tk;
        e.r = 0; e.np = o.pc + 4; e.d = 0; e.lat = 1;
        sh = int'(o.b[4:0]);
        if (o.fl[5]) begin
            case (o.f3)
                3'd0: tk = (o.a == o.b);
                3'd1: tk = (o.a != o.b);
                3'd4: tk = ($signed(o.a) < $signed(o.b));
                3'd5: tk = ($signed(o.a) >= $signed(o.b));
                3'd6: tk = (o.a < o.b);
                3'd7: tk = (o.a >= o.b);
                default: tk = 0;
            endcase
            if (tk) e.np = o.pc + o.bd;
        end else if (o.fl[4]) begin
            e.r = o.pc + 4; e.d = o.d;
            e.np = o.fl[0] ? ((o.a + o.b) & 32'hFFFF_FFFE) : (o.pc + o.a);
        end else if (o.fl[3] || o.fl[2]) begin
            e.r = o.a + o.b;
            e.d = o.fl[3] ? o.d : 5'd0;
        end else if (o.fl[1]) begin
            e.d = o.d;
            case (o.f3)
                3'd0: e.r = o.f7 ? o.a - o.b : o.a + o.b;
                3'd2: e.r = ($signed(o.a) < $signed(o.b)) ? 1 : 0;
                3'd3: e.r = (o.a < o.b) ? 1 : 0;
                3'd4: e.r = o.a ^ o.b;
                3'd6: e.r = o.a | o.b;
                3'd7: e.r = o.a & o.b;
                3'd1: e.r = o.a << sh;
                default: e.r = o.f7 ? 32'($signed(o.a) >>> sh) : (o.a >> sh);
            endcase
            if ((o.f3 == 3'd1 || o.f3 == 3'd5) && sh != 0) e.lat = 1 + (sh + step - 1) / step;
        end
        return e;
    endfunction

    task automatic do_op(input op_t o, input bit s, input exp_t e, input string tag);
        int n;
        int lat;
        sel = s; cur = o; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!i_ready && n < 100) begin @(posedge clk); #1; n++; end
        check({tag, ".in_ready"}, 64'(i_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        if (e.lat > 1) check({tag, ".busy"}, 64'(o_busy), 64'd1);
        while (!o_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        check({tag, ".latency"}, 64'(lat), 64'(e.lat));
        check({tag, ".result"}, 64'(o_result), 64'(e.r));
        check({tag, ".next_pc"}, 64'(o_npc), 64'(e.np));
        check({tag, ".dest_o"}, 64'(o_dest), 64'(e.d));
    endtask

    vec_t vecs[18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   seen;
        op_t  o;
        exp_t e;
        bit   s;

        vecs[0]  = '{mkop(F_BR, 200, 200, 20, 20, 5, 3'd0, 0), 0, '{0, 40, 0, 1}};
        vecs[1]  = '{mkop(F_BR, 32'd2200000000, 10, 100, 20, 5, 3'd6, 0), 0, '{0, 24, 0, 1}};
        vecs[2]  = '{mkop(F_JP | F_RG, 32, 17, 0, 4, 11, 3'd0, 0), 0, '{8, 48, 11, 1}};
        vecs[3]  = '{mkop(F_JP, 20000, 0, 0, 20, 1, 3'd0, 0), 1, '{24, 20020, 1, 1}};
        vecs[4]  = '{mkop(F_AL, 100, 32'hFFFF_FF38, 0, 0, 3, 3'd0, 0), 0, '{32'hFFFF_FF9C, 4, 3, 1}};
        vecs[5]  = '{mkop(F_AL, 5, 7, 0, 8, 2, 3'd0, 1), 1, '{32'hFFFF_FFFE, 12, 2, 1}};
        vecs[6]  = '{mkop(F_AL, 32'hFFFF_FFFF, 1, 0, 0, 6, 3'd2, 0), 0, '{1, 4, 6, 1}};
        vecs[7]  = '{mkop(F_AL, 32'hFFFF_FFFF, 1, 0, 0, 6, 3'd3, 0), 0, '{0, 4, 6, 1}};
        vecs[8]  = '{mkop(F_LD, 32'h1000, 32'h24, 0, 8, 7, 3'd0, 0), 0, '{32'h1024, 12, 7, 1}};
        vecs[9]  = '{mkop(F_ST, 32'h1000, 32'h24, 0, 8, 7, 3'd0, 0), 1, '{32'h1024, 12, 0, 1}};
        vecs[10] = '{mkop(6'd0, 5, 6, 0, 100, 9, 3'd0, 0), 0, '{0, 104, 0, 1}};
        vecs[11] = '{mkop(F_BR, 1, 1, 64, 0, 3, 3'd2, 0), 0, '{0, 4, 0, 1}};
        vecs[12] = '{mkop(F_BR | F_JP | F_AL, 1, 2, 8, 0, 3, 3'd0, 0), 0, '{0, 4, 0, 1}};
        vecs[13] = '{mkop(F_AL, 32'h8000_0000, 31, 0, 0, 4, 3'd5, 1), 0, '{32'hFFFF_FFFF, 4, 4, 32}};
        vecs[14] = '{mkop(F_AL, 1, 5, 0, 0, 4, 3'd1, 0), 1, '{32, 4, 4, 3}};
        vecs[15] = '{mkop(F_AL, 32'h1234, 32, 0, 0, 4, 3'd5, 0), 1, '{32'h1234, 4, 4, 1}};
        vecs[16] = '{mkop(F_BR, 32'hFFFF_FFFF, 1, 32, 16, 2, 3'd4, 0), 0, '{0, 48, 0, 1}};
        vecs[17] = '{mkop(F_AL, 32'h8000_00F0, 7, 0, 12, 8, 3'd5, 0), 1, '{32'h0100_0001, 16, 8, 3}};

        // Reset: everything cleared, then ready once released
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid1", 64'(if1.out_valid), 0);
        check("rst.out_valid4", 64'(if4.out_valid), 0);
        check("rst.busy1", 64'(if1.busy), 0);
        check("rst.result1", 64'(if1.result), 0);
        check("rst.next_pc1", 64'(if1.next_pc), 0);
        check("rst.dest_o4", 64'(if4.dest_o), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst.in_ready1", 64'(if1.in_ready), 1);
        check("rst.in_ready4", 64'(if4.in_ready), 1);
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++)
            do_op(vecs[i].op, vecs[i].sel, vecs[i].e, $sformatf("vec%0d", i));

        // Backpressure: held output, then drain and accept on one edge
        @(posedge clk); #1;
        sel = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        cur = mkop(F_AL, 100, 32'hFFFF_FF38, 0, 0, 3, 3'd0, 0);
        check("bp.accept_ready", 64'(i_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp.hold%0d.valid", k), 64'(o_valid), 1);
            check($sformatf("bp.hold%0d.result", k), 64'(o_result), 64'h0000_0000_FFFF_FF9C);
            check($sformatf("bp.hold%0d.in_ready", k), 64'(i_ready), 0);
            @(posedge clk); #1;
        end
        cur = mkop(F_AL, 10, 3, 0, 40, 4, 3'd0, 1);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp.drain_ready", 64'(i_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.new.valid", 64'(o_valid), 1);
        check("bp.new.result", 64'(o_result), 7);
        check("bp.new.dest_o", 64'(o_dest), 4);
        @(posedge clk); #1;
        check("bp.drained", 64'(o_valid), 0);

        // Reset in the middle of a 20-cycle shift
        sel = 1'b0; in_valid = 1'b1;
        cur = mkop(F_AL, 1, 20, 0, 0, 9, 3'd1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mrst.busy_before", 64'(o_busy), 1);
        #2 reset = 1'b0;
        #1;
        check("mrst.busy_async", 64'(o_busy), 0);
        check("mrst.valid_async", 64'(o_valid), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        check("mrst.no_valid", 64'(seen), 0);
        do_op(mkop(F_AL, 32'h00F0, 32'h0F0F, 0, 64, 12, 3'd4, 0), 0, '{32'h0FFF, 68, 12, 1}, "mrst.next");

        // Random ops against the reference model, both shifter widths
        for (int i = 0; i < 300; i++) begin
            o.a = $urandom; o.b = $urandom; o.bd = $urandom; o.pc = $urandom;
            o.d = 5'($urandom); o.f3 = 3'($urandom); o.f7 = 1'($urandom);
            case ($urandom_range(0, 5))
                0: o.fl = F_BR;
                1: o.fl = F_JP;
                2: o.fl = F_LD;
                3: o.fl = F_ST;
                4: o.fl = F_AL;
                default: o.fl = 6'd0;
            endcase
            if ($urandom_range(0, 7) == 0) o.fl = o.fl | 6'($urandom);
            o.fl[0] = 1'($urandom);
            if ($urandom_range(0, 3) == 0) o.a = o.b;
            s = 1'($urandom);
            e = model(o, s ? 4 : 1);
            do_op(o, s, e, $sformatf("rnd%0d", i));
        end

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/execute_mc.md
EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 Parameter XLEN, 32, datapath width of operands, result, pc; legal values 32 and 64.
REQ-002 Parameter SHIFT_STEP, 1, bit positions shifted per cycle by the iterative shifter; a power of two, 1..XLEN.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-005 in_valid  in  1  upstream presents an operation; in_ready  out  1  stage can accept one.
REQ-006 is_store, is_load, is_branch, is_jump, is_reg, is_alu  in  1 each  operation class flags.
REQ-007 operand_a, operand_b, branch_dest, curr_pc  in  XLEN each  operands, branch offset, pc of the operation.
REQ-008 dest_i  in  5  destination register; func3  in  3  sub-op; func7  in  1  alt-op bit (sub/sra).
REQ-009 out_valid  out  1  result presented; out_ready  in  1  downstream accepts it.
REQ-010 result, next_pc  out  XLEN each; dest_o  out  5; busy  out  1  high while the shifter iterates.

Function
REQ-011 Transfer on clk edge when in_valid && in_ready; operands and flags captured in that edge; inputs otherwise ignored.
REQ-012 in_ready = (state == IDLE) && (!out_valid || out_ready); simultaneous accept and output drain in one edge is legal.
REQ-013 States: IDLE (accept), SHIFT (iterate), no other states; out_valid is a separate register.
REQ-014 Class priority if several flags set: is_branch > is_jump > is_load/is_store > is_alu; none set -> nop: result 0, dest_o 0, next_pc curr_pc+4.
REQ-015 Branch: func3 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu (signed/unsigned compare over XLEN); taken -> next_pc = curr_pc + branch_dest, else curr_pc + 4; result 0, dest_o 0; func3 010/011 -> not taken.
REQ-016 Jump: result = curr_pc + 4, dest_o = dest_i; is_reg 0 (jal) -> next_pc = curr_pc + operand_a; is_reg 1 (jalr) -> next_pc = (operand_a + operand_b) & ~1.
REQ-017 Load/store: result = operand_a + operand_b (address), next_pc = curr_pc + 4; dest_o = dest_i for load, 0 for store.
REQ-018 ALU: func3 000 add (func7 0) / sub (func7 1), 010 slt, 011 sltu, 100 xor, 110 or, 111 and, 001 sll, 101 srl (func7 0) / sra (func7 1); next_pc = curr_pc + 4, dest_o = dest_i.
REQ-019 All arithmetic modulo 2^XLEN; carries discarded; slt/sltu yield 0 or 1 zero-extended.
REQ-020 Non-shift ops: out_valid rises the edge after acceptance (latency 1), outputs registered.
REQ-021 Shifts: shamt = operand_b[log2(XLEN)-1:0]; shamt 0 -> latency 1, result = operand_a; else SHIFT entered, shifting min(SHIFT_STEP, remaining) per cycle; latency = 1 + ceil(shamt/SHIFT_STEP) cycles.
REQ-022 sra fills with operand_a[XLEN-1]; sll/srl fill with 0.
REQ-023 busy = (state == SHIFT); in_ready 0 and out_valid 0 throughout SHIFT.
REQ-024 While out_valid && !out_ready, result, next_pc, dest_o held stable and no new op accepted.
REQ-025 out_valid falls the edge it is consumed unless a new op completes on that same edge.

Reset
REQ-026 reset low: state IDLE, out_valid 0, busy 0, result 0, next_pc 0, dest_o 0; in_ready 1 once reset is released.
REQ-027 reset asserted mid-shift aborts the operation; no out_valid is produced for it.

Verification
REQ-028 reset low for 2 cycles -> outputs all 0, out_valid 0; after release in_ready 1.
REQ-029 beq a=200,b=200,curr_pc=20,branch_dest=20 -> next cycle out_valid, next_pc 40, dest_o 0; bltu a=2200000000,b=10,curr_pc=20 -> next_pc 24.
REQ-030 jalr a=32,b=17,dest_i=11,curr_pc=4 -> result 8, next_pc 48, dest_o 11; jal a=20000,curr_pc=20 -> next_pc 20020, result 24.
REQ-031 SHIFT_STEP=1, sra a=0x80000000,b=31 -> busy 31 cycles, out_valid at cycle 32, result 0xFFFFFFFF; SHIFT_STEP=4, sll a=1,b=5 -> latency 3, result 32.
REQ-032 out_ready held 0 for 3 cycles after add a=100,b=-200 -> result -100 held stable, in_ready 0; out_ready 1 with in_valid 1 -> drain and accept on same edge.
REQ-033 reset pulsed low during a 20-cycle shift -> out_valid never rises for it; next op after release completes normally.
